// File: rtl/sqrt_bcd_display.sv
// sqrt_bcd_display
//   Display stage for the square-root unit. Accepts a binary value over a
//   valid/ready handshake, converts it to BCD with a bit-serial double-dabble
//   engine (one input bit per clock), and drives a time-multiplexed,
//   active-low 7-segment display with optional leading-zero blanking.
//   The display keeps showing the last completed value while a new
//   conversion is in progress.
//
// Ports
//   clk        clock, everything on posedge
//   rst        synchronous active-high reset
//   in_valid   in_data is valid
//   in_data    unsigned binary value to display (DATA_W bits)
//   in_ready   high only while idle; transfer = in_valid & in_ready
//   bcd_out    last converted value, digit 0 (units) in [3:0]
//   bcd_valid  one-cycle pulse when bcd_out updates
//   seg        {g,f,e,d,c,b,a}, active low, for the digit selected by an
//   an         anode select, active low, exactly one bit low
module sqrt_bcd_display #(
    parameter int DATA_W      = 10,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DATA_W + 1);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // The BCD scratch must hold the largest input, otherwise the top
    // nibble would overflow silently during conversion.
    generate
        if (((longint'(1) << DATA_W) - 1) > (pow10(DIGITS) - 1)) begin : g_width_check
            $error("sqrt_bcd_display: DATA_W too wide for DIGITS");
        end
    endgenerate

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     scratch, scratch_adj;
    logic [CW-1:0]     bit_cnt;

    assign in_ready = (state == IDLE);

    // Add-3 correction on every nibble that would exceed 9 after doubling.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = CONV;
            CONV:    if (bit_cnt == CW'(DATA_W - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            scratch   <= '0;
            bit_cnt   <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg   <= in_data;
                        scratch <= '0;
                        bit_cnt <= '0;
                    end
                end
                CONV: begin
                    // The adjusted top bit is always zero (width check), so
                    // truncating it on the shift loses nothing.
                    scratch <= BW'({scratch_adj, shreg[DATA_W-1]});
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                DONE: begin
                    bcd_out   <= scratch;
                    bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display refresh: free-running, independent of the FSM
    // ------------------------------------------------------------------
    logic [RW-1:0]     ref_cnt;
    logic [IW-1:0]     idx;
    logic [DIGITS-1:0] blank;
    logic [6:0]        seg_nx;

    // A digit is blank when it and everything above it are zero; digit 0
    // is never blanked so a zero value still shows "0".
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank      = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (bcd_out[4*i +: 4] == 4'd0);
            blank[i]   = (BLANK_LZ != 0) && (i != 0) && zero_above;
        end
    end

    always_comb begin
        seg_nx = 7'b1111111;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i))
                seg_nx = blank[i] ? 7'b1111111 : seg_decode(bcd_out[4*i +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
            idx     <= '0;
            an      <= ~DIGITS'(1);
            seg     <= 7'b1000000;
        end else begin
            if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            an  <= ~(DIGITS'(1) << idx);
            seg <= seg_nx;
        end
    end

endmodule

// File: tb/tb_sqrt_bcd_display.sv
// Testbench for sqrt_bcd_display (DATA_W=10, DIGITS=4, REFRESH_DIV=4).
// Accepted inputs are converted to expected BCD by decimal division and
// queued; every bcd_valid pulse pops and compares. Directed checks cover
// reset values, handshake latency, display scan and blanking, and reset
// in the middle of a conversion.
module tb_sqrt_bcd_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [9:0]  in_data;
    logic        in_ready;
    logic [15:0] bcd_out;
    logic        bcd_valid;
    logic [6:0]  seg;
    logic [3:0]  an;

    sqrt_bcd_display #(
        .DATA_W(10), .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .bcd_out(bcd_out), .bcd_valid(bcd_valid),
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [15:0] exp_q[$];
    bit spacing_on = 1'b0;
    int last_acc   = -1;

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: values at negedge equal what the DUT sees at the next edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bcd_valid) begin
                if (exp_q.size() == 0) chk("unexp_valid", 1, 0);
                else                   chk("sb_bcd", bcd_out, exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(to_bcd(int'(in_data)));
                if (spacing_on && last_acc >= 0) chk("spacing", cyc + 1 - last_acc, 12);
                last_acc = cyc + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the transfer edge.
    task automatic send(input int v);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = 10'(v);
        for (int k = 0; k < 50 && !done; k++) begin
            done = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            step();
            k++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        step();
    endtask

    task automatic disp_check(input int val, input int n);
        logic [3:0] prev_an = 4'b0000;
        int run = 0;
        bit seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            int idx = -1;
            int p   = 1;
            step();
            for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) idx = i;
            chk("an_onehot", (idx >= 0), 1);
            if (idx >= 0) begin
                for (int i = 0; i < idx; i++) p = p * 10;
                if (idx > 0 && val < p) chk("seg_blank", seg, 7'b1111111);
                else                    chk("seg_digit", seg, seg_tbl[(val / p) % 10]);
            end
            if (k > 0 && an != prev_an) begin
                if (seen) chk("an_run", run, 4);
                chk("an_next", an, {prev_an[2:0], prev_an[3]});
                seen = 1'b1;
                run  = 1;
            end else begin
                run++;
            end
            prev_an = an;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        // 1: reset values
        step(); step();
        chk("rst_ready", in_ready, 1);
        chk("rst_bcd", bcd_out, 0);
        chk("rst_an", an, 4'b1110);
        chk("rst_seg", seg, 7'b1000000);
        chk("rst_valid", bcd_valid, 0);
        rst = 1'b0;
        step();

        // 2: latency for 31
        send(31);
        chk("lat_rdy_T", in_ready, 0);
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k <= 10) begin
                chk("lat_rdy_low", in_ready, 0);
                chk("lat_no_valid", bcd_valid, 0);
            end else begin
                chk("lat_valid", bcd_valid, 1);
                chk("lat_bcd", bcd_out, 16'h0031);
                chk("lat_rdy_high", in_ready, 1);
            end
        end
        step();
        chk("lat_pulse_end", bcd_valid, 0);

        // 3: max value, then zero with blanking
        send(1023);
        wait_drain();
        chk("bcd_1023", bcd_out, 16'h1023);
        disp_check(1023, 12);
        send(0);
        wait_drain();
        chk("bcd_0", bcd_out, 16'h0000);
        disp_check(0, 16);

        // 4: in_valid held with changing data
        spacing_on = 1'b1;
        last_acc   = -1;
        in_valid   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            in_data = 10'($urandom_range(0, 1023));
            step();
        end
        in_valid   = 1'b0;
        spacing_on = 1'b0;
        wait_drain();

        // 5: scan of 7
        send(7);
        wait_drain();
        chk("bcd_7", bcd_out, 16'h0007);
        disp_check(7, 34);

        // 6: reset mid-conversion of 500
        send(500);
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("abort_ready", in_ready, 1);
        chk("abort_bcd", bcd_out, 0);
        chk("abort_valid", bcd_valid, 0);
        chk("abort_an", an, 4'b1110);
        chk("abort_seg", seg, 7'b1000000);
        rst = 1'b0;
        repeat (20) step();
        chk("abort_bcd_hold", bcd_out, 0);

        // recovery
        send(999);
        wait_drain();
        chk("bcd_999", bcd_out, 16'h0999);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
